// File: rtl/mask_sequencer_pkg.sv
// Shared types for the mask sequencer: op and FSM encodings, command payload,
// lowmask table and a small rotate helper.
package mask_sequencer_pkg;

    localparam int unsigned W     = 8;
    localparam int unsigned POS_W = 3;

    typedef enum logic {
        OP_EXTRACT = 1'b0,
        OP_INSERT  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef enum logic {
        ROT_RIGHT = 1'b0,
        ROT_LEFT  = 1'b1
    } rot_dir_e;

    typedef struct packed {
        op_e              op;
        logic [POS_W-1:0] pos;
        logic [POS_W-1:0] len;
        logic [W-1:0]     src;
        logic [W-1:0]     dst;
    } cmd_t;

    // Index 0 is the "full width" encoding, matching the mask unit's L_select.
    localparam logic [7:0][W-1:0] LOWMASK_TAB = {
        8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'hFF
    };

    function automatic logic [W-1:0] lowmask(input logic [POS_W-1:0] len);
        return LOWMASK_TAB[len];
    endfunction

    function automatic logic [W-1:0] rotl8(input logic [W-1:0] d, input logic [POS_W-1:0] amt);
        logic [2*W-1:0] dbl;
        dbl = {d, d} << amt;
        return dbl[2*W-1:W];
    endfunction

endpackage

// File: rtl/mask_sequencer_if.sv
// Command and result channels between the execute stage and the mask sequencer.
interface mask_sequencer_if;
    import mask_sequencer_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [POS_W-1:0] cmd_pos;
    logic [POS_W-1:0] cmd_len;
    logic [W-1:0]     cmd_src;
    logic [W-1:0]     cmd_dst;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;

    modport master (
        output cmd_valid, cmd_op, cmd_pos, cmd_len, cmd_src, cmd_dst, res_ready,
        input  cmd_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_pos, cmd_len, cmd_src, cmd_dst, res_ready,
        output cmd_ready, res_valid, res_data
    );

endinterface

// File: rtl/mask_sequencer_rotator8.sv
// Combinational 8-bit barrel rotator, direction selectable.
module rotator8
    import mask_sequencer_pkg::*;
(
    input  rot_dir_e         dir,
    input  logic [POS_W-1:0] amt,
    input  logic [W-1:0]     data,
    output logic [W-1:0]     result_c
);

    logic [2*W-1:0] dbl_c;

    // Shifting a doubled copy gives the wrap-around bits for free.
    always_comb begin
        dbl_c    = {data, data};
        result_c = '0;
        if (dir == ROT_RIGHT) begin
            dbl_c    = dbl_c >> amt;
            result_c = dbl_c[W-1:0];
        end else begin
            dbl_c    = dbl_c << amt;
            result_c = dbl_c[2*W-1:W];
        end
    end

endmodule

// File: rtl/mask_sequencer.sv
// Drives the external 8-bit mask unit through one EXTRACT/INSERT bit-field op at a time.
module mask_sequencer
    import mask_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    mask_sequencer_if.slave  bus,
    output logic [W-1:0]     mask_in_o,
    output logic [POS_W-1:0] mask_lsel_o,
    output logic             mask_hold_o,
    input  logic [W-1:0]     mask_out_i
);

    state_e       state;
    state_e       state_next;
    cmd_t         cmd_q;
    logic [W-1:0] res_data_q;
    logic         res_valid_q;

    logic         cmd_ready_c;
    logic         hold_c;
    logic         accept_c;
    logic         capture_c;
    logic [W-1:0] issue_rot_c;
    logic [W-1:0] merge_rot_c;
    logic [W-1:0] field_mask_c;
    logic [W-1:0] capture_data_c;

    // Issue path: EXTRACT pre-rotates the source so the field sits at bit 0.
    rotator8 u_rot_issue (
        .dir      (ROT_RIGHT),
        .amt      (cmd_q.pos),
        .data     (cmd_q.src),
        .result_c (issue_rot_c)
    );

    // Merge path: INSERT moves the masked field back up to its position.
    rotator8 u_rot_merge (
        .dir      (ROT_LEFT),
        .amt      (cmd_q.pos),
        .data     (mask_out_i),
        .result_c (merge_rot_c)
    );

    always_comb begin
        field_mask_c = rotl8(lowmask(cmd_q.len), cmd_q.pos);
        if (cmd_q.op == OP_EXTRACT) begin
            capture_data_c = mask_out_i;
        end else begin
            capture_data_c = (cmd_q.dst & ~field_mask_c) | (merge_rot_c & field_mask_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake controls; stall freezes every transition.
    always_comb begin
        state_next  = state;
        cmd_ready_c = 1'b0;
        hold_c      = 1'b1;
        accept_c    = 1'b0;
        capture_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready_c = ~stall;
                if (!stall && bus.cmd_valid) begin
                    accept_c   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    hold_c     = 1'b0;
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!stall) begin
                    capture_c  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!stall && bus.res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (accept_c) begin
                cmd_q.op  <= op_e'(bus.cmd_op);
                cmd_q.pos <= bus.cmd_pos;
                cmd_q.len <= bus.cmd_len;
                cmd_q.src <= bus.cmd_src;
                cmd_q.dst <= bus.cmd_dst;
            end
            if (capture_c) begin
                res_data_q <= capture_data_c;
            end
            res_valid_q <= (state_next == ST_DONE);
        end
    end

    // Mask-unit drive comes straight from the command register; it only matters while hold is low.
    assign mask_in_o     = (cmd_q.op == OP_EXTRACT) ? issue_rot_c : cmd_q.src;
    assign mask_lsel_o   = cmd_q.len;
    assign mask_hold_o   = hold_c;
    assign bus.cmd_ready = cmd_ready_c;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_mask_sequencer.sv
// Self-checking bench for mask_sequencer with a behavioural mask unit and reference model.
module tb_mask_sequencer;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       stall = 1'b0;
    logic [7:0] mask_in;
    logic [2:0] mask_lsel;
    logic       mask_hold;
    logic [7:0] mask_out = 8'h00;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    mask_sequencer_if bus ();

    mask_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .bus         (bus),
        .mask_in_o   (mask_in),
        .mask_lsel_o (mask_lsel),
        .mask_hold_o (mask_hold),
        .mask_out_i  (mask_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lm(input logic [2:0] len);
        int n;
        n = (len == 3'd0) ? 8 : int'(len);
        return 8'((1 << n) - 1);
    endfunction

    // Mask unit stand-in: registered low-n-bit mask, frozen while hold is high.
    always @(posedge clk) begin
        if (mask_hold === 1'b0) mask_out <= mask_in & lm(mask_lsel);
    end

    function automatic logic [7:0] rot_right(input logic [7:0] s, input logic [2:0] p);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = s[(i + int'(p)) % 8];
        return r;
    endfunction

    function automatic logic [7:0] ref_result(input logic op, input logic [2:0] pos, input logic [2:0] len,
                                              input logic [7:0] src, input logic [7:0] dst);
        logic [7:0] r;
        int n;
        n = (len == 3'd0) ? 8 : int'(len);
        r = op ? dst : 8'h00;
        for (int i = 0; i < n; i++) begin
            if (op) r[(i + int'(pos)) % 8] = src[i];
            else    r[i] = src[(i + int'(pos)) % 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks one op in flight by counting unstalled edges since accept.
    bit         m_busy = 1'b0;
    int         m_cnt  = 0;
    int         n_done = 0;
    logic [7:0] m_last = 8'h00;
    logic [7:0] m_exp  = 8'h00;
    logic [7:0] m_min  = 8'h00;
    logic [2:0] m_len  = 3'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_last = 8'h00;
        end else if (!stall) begin
            if (!m_busy) begin
                if (bus.cmd_valid) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    m_len  = bus.cmd_len;
                    m_min  = bus.cmd_op ? bus.cmd_src : rot_right(bus.cmd_src, bus.cmd_pos);
                    m_exp  = ref_result(bus.cmd_op, bus.cmd_pos, bus.cmd_len, bus.cmd_src, bus.cmd_dst);
                end
            end else if (m_cnt >= 2) begin
                if (bus.res_ready) begin
                    m_busy = 1'b0;
                    n_done++;
                end
            end else begin
                m_cnt++;
                if (m_cnt == 2) m_last = m_exp;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit issue;
            issue = m_busy && (m_cnt == 0);
            check("cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy && !stall));
            check("res_valid", 32'(bus.res_valid), 32'(m_busy && m_cnt >= 2));
            check("res_data",  32'(bus.res_data),  32'(m_last));
            check("mask_hold", 32'(mask_hold),     32'(!(issue && !stall)));
            if (issue) begin
                check("mask_lsel", 32'(mask_lsel), 32'(m_len));
                check("mask_in",   32'(mask_in),   32'(m_min));
            end
        end
    end

    task automatic scramble();
        bus.cmd_op  = 1'($urandom);
        bus.cmd_pos = 3'($urandom);
        bus.cmd_len = 3'($urandom);
        bus.cmd_src = 8'($urandom);
        bus.cmd_dst = 8'($urandom);
    endtask

    task automatic send(input logic op, input logic [2:0] pos, input logic [2:0] len,
                        input logic [7:0] src, input logic [7:0] dst);
        bit done;
        done = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_pos   = pos;
        bus.cmd_len   = len;
        bus.cmd_src   = src;
        bus.cmd_dst   = dst;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.cmd_ready === 1'b1) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) check("accept_timeout", 32'(0), 32'(1));
        bus.cmd_valid = 1'b0;
        scramble();
    endtask

    task automatic get_result(input logic [7:0] exp, input int hold_cycles, input string name, output int lat);
        lat = 1;
        while (bus.res_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_valid"}, 32'(bus.res_valid), 32'(1));
        check(name, 32'(bus.res_data), 32'(exp));
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk); #1;
            check({name, "_hold_valid"}, 32'(bus.res_valid), 32'(1));
            check({name, "_hold_data"},  32'(bus.res_data),  32'(exp));
            check({name, "_hold_ready"}, 32'(bus.cmd_ready), 32'(0));
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check({name, "_release_valid"}, 32'(bus.res_valid), 32'(0));
        check({name, "_release_ready"}, 32'(bus.cmd_ready), 32'(1));
    endtask

    initial begin
        int lat;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        scramble();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        check("rst_res_valid", 32'(bus.res_valid), 32'(0));
        check("rst_res_data",  32'(bus.res_data),  32'(8'h00));
        check("rst_hold",      32'(mask_hold),     32'(1));
        check("rst_lsel",      32'(mask_lsel),     32'(0));
        check("rst_mask_in",   32'(mask_in),       32'(8'h00));
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));

        send(1'b0, 3'd2, 3'd3, 8'hB6, 8'h00);
        check("issue_lsel", 32'(mask_lsel), 32'(3));
        check("issue_hold", 32'(mask_hold), 32'(0));
        get_result(8'h05, 0, "ext_b6", lat);
        check("latency", 32'(lat), 32'(3));

        send(1'b0, 3'd4, 3'd0, 8'h5A, 8'h00);
        get_result(8'hA5, 0, "ext_full", lat);

        send(1'b1, 3'd6, 3'd4, 8'h0F, 8'h00);
        get_result(8'hC3, 0, "ins_wrap", lat);

        send(1'b1, 3'd3, 3'd2, 8'h00, 8'hFF);
        get_result(8'hE7, 5, "ins_clear", lat);

        // Stall held across the whole ISSUE cycle.
        send(1'b0, 3'd2, 3'd3, 8'hB6, 8'h00);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_hold", 32'(mask_hold), 32'(1));
            check("stall_ready", 32'(bus.cmd_ready), 32'(0));
            @(posedge clk); #1;
        end
        stall = 1'b0;
        #1;
        check("stall_issue_hold", 32'(mask_hold), 32'(0));
        get_result(8'h05, 0, "ext_stalled", lat);

        // Reset in CAPTURE discards the op.
        send(1'b1, 3'd6, 3'd4, 8'h0F, 8'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", 32'(bus.res_valid), 32'(0));
        check("midrst_hold",  32'(mask_hold),     32'(1));
        check("midrst_ready", 32'(bus.cmd_ready), 32'(1));
        check("midrst_data",  32'(bus.res_data),  32'(8'h00));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("midrst_quiet", 32'(bus.res_valid), 32'(0));
        end

        // Randomised traffic with stalls, backpressure and occasional reset.
        for (int c = 0; c < 4000; c++) begin
            stall         = ($urandom_range(0, 5) == 0);
            rst           = ($urandom_range(0, 299) == 0);
            bus.res_ready = 1'($urandom);
            bus.cmd_valid = ($urandom_range(0, 2) != 0);
            scramble();
            @(posedge clk); #1;
        end
        stall         = 1'b0;
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("random_results_seen", 32'(n_done > 100), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
